mc_read_arbiter: RTL and testbench



---
 rtl/mc_read_arbiter.sv | 145 ++++++++++++++
 tb/tb_mc_read_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mc_read_arbiter.sv
// mc_read_arbiter: shares the memory-controller AR channel between the tag-lookup
// requester (T) and the miss-fill requester (F). Arbitration is round-robin, the AR
// output is registered, and each side may have at most MAX_OUTSTANDING reads in
// flight. Returning R beats are steered back by the source bit in rid_i's MSB.
module mc_read_arbiter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester T AR
  input  logic [ID_WIDTH-1:0]   t_arid_i,
  input  logic [ADDR_WIDTH-1:0] t_araddr_i,
  input  logic                  t_arvalid_i,
  output logic                  t_arready_o,
  // requester F AR
  input  logic [ID_WIDTH-1:0]   f_arid_i,
  input  logic [ADDR_WIDTH-1:0] f_araddr_i,
  input  logic                  f_arvalid_i,
  output logic                  f_arready_o,
  // memory controller AR
  output logic [ID_WIDTH:0]     arid_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  // memory controller R
  input  logic [ID_WIDTH:0]     rid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  // requester T R
  output logic [ID_WIDTH-1:0]   t_rid_o,
  output logic [DATA_WIDTH-1:0] t_rdata_o,
  output logic                  t_rlast_o,
  output logic                  t_rvalid_o,
  input  logic                  t_rready_i,
  // requester F R
  output logic [ID_WIDTH-1:0]   f_rid_o,
  output logic [DATA_WIDTH-1:0] f_rdata_o,
  output logic                  f_rlast_o,
  output logic                  f_rvalid_o,
  input  logic                  f_rready_i,
  output logic                  err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic SRC_T = 1'b0;
  localparam logic SRC_F = 1'b1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] cnt_t, cnt_f;
  logic          t_elig, f_elig;
  logic          grant_t, grant_f;
  logic          r_dst, r_done, dec_t, dec_f;

  // Eligibility and round-robin grant; only decided while the AR slot is free
  always_comb begin
    t_elig  = t_arvalid_i && (cnt_t < CNT_MAX);
    f_elig  = f_arvalid_i && (cnt_f < CNT_MAX);
    grant_t = 1'b0;
    grant_f = 1'b0;
    if (state == S_IDLE) begin
      grant_t = t_elig && (!f_elig || last_grant == SRC_F);
      grant_f = f_elig && (!t_elig || last_grant == SRC_T);
    end
    // ready must stay low while reset is held, even though state already reads idle
    t_arready_o = grant_t && rst_n;
    f_arready_o = grant_f && rst_n;
  end

  // R routing: zero latency, steered by the source bit carried in the ID MSB
  always_comb begin
    r_dst      = rid_i[ID_WIDTH];
    t_rvalid_o = rvalid_i && !r_dst;
    f_rvalid_o = rvalid_i &&  r_dst;
    rready_o   = r_dst ? f_rready_i : t_rready_i;
    t_rid_o    = rid_i[ID_WIDTH-1:0];
    f_rid_o    = rid_i[ID_WIDTH-1:0];
    t_rdata_o  = rdata_i;
    f_rdata_o  = rdata_i;
    t_rlast_o  = rlast_i;
    f_rlast_o  = rlast_i;
    r_done     = rvalid_i && rready_o && rlast_i;
    dec_t      = r_done && !r_dst;
    dec_f      = r_done &&  r_dst;
  end

  // AR FSM: latch the winner into the output register and hold it until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= SRC_F;
      arvalid_o  <= 1'b0;
      arid_o     <= '0;
      araddr_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_t || grant_f) begin
            arvalid_o  <= 1'b1;
            arid_o     <= grant_f ? {SRC_F, f_arid_i} : {SRC_T, t_arid_i};
            araddr_o   <= grant_f ? f_araddr_i : t_araddr_i;
            last_grant <= grant_f ? SRC_F : SRC_T;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outstanding counters: +1 on grant, -1 on last beat, saturate at 0 and flag underflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_t <= '0;
      cnt_f <= '0;
      err_o <= 1'b0;
    end else begin
      if (grant_t && !dec_t)
        cnt_t <= cnt_t + CW'(1);
      else if (dec_t && !grant_t && cnt_t != '0)
        cnt_t <= cnt_t - CW'(1);
      if (grant_f && !dec_f)
        cnt_f <= cnt_f + CW'(1);
      else if (dec_f && !grant_f && cnt_f != '0)
        cnt_f <= cnt_f - CW'(1);
      if ((dec_t && cnt_t == '0) || (dec_f && cnt_f == '0))
        err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_read_arbiter.sv
// Directed bench for mc_read_arbiter: reset, round-robin, throttle, backpressure,
// R routing and the sticky underflow error, with hand-computed expectations.
module tb_mc_read_arbiter;
  localparam int AW = 64, DW = 32, IW = 16, MO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] t_arid_i, f_arid_i;
  logic [AW-1:0] t_araddr_i, f_araddr_i;
  logic          t_arvalid_i, f_arvalid_i, t_arready_o, f_arready_o;
  logic [IW:0]   arid_o;
  logic [AW-1:0] araddr_o;
  logic          arvalid_o, arready_i;
  logic [IW:0]   rid_i;
  logic [DW-1:0] rdata_i;
  logic          rlast_i, rvalid_i, rready_o;
  logic [IW-1:0] t_rid_o, f_rid_o;
  logic [DW-1:0] t_rdata_o, f_rdata_o;
  logic          t_rlast_o, f_rlast_o, t_rvalid_o, f_rvalid_o;
  logic          t_rready_i, f_rready_i, err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .t_arid_i(t_arid_i), .t_araddr_i(t_araddr_i), .t_arvalid_i(t_arvalid_i), .t_arready_o(t_arready_o),
    .f_arid_i(f_arid_i), .f_araddr_i(f_araddr_i), .f_arvalid_i(f_arvalid_i), .f_arready_o(f_arready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .t_rid_o(t_rid_o), .t_rdata_o(t_rdata_o), .t_rlast_o(t_rlast_o), .t_rvalid_o(t_rvalid_o), .t_rready_i(t_rready_i),
    .f_rid_o(f_rid_o), .f_rdata_o(f_rdata_o), .f_rlast_o(f_rlast_o), .f_rvalid_o(f_rvalid_o), .f_rready_i(f_rready_i),
    .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [IW-1:0] TID = 16'h0012, FID = 16'h0034;
  localparam logic [AW-1:0] TADDR = 64'h40, FADDR = 64'h80;

  initial begin
    rst_n = 1'b0;
    t_arid_i = TID; t_araddr_i = TADDR; f_arid_i = FID; f_araddr_i = FADDR;
    t_arvalid_i = 1'b1; f_arvalid_i = 1'b1; arready_i = 1'b1;
    rid_i = '0; rdata_i = '0; rlast_i = 1'b0; rvalid_i = 1'b0;
    t_rready_i = 1'b1; f_rready_i = 1'b1;

    // reset values, with both requesters already valid
    #3;
    chk("rst_t_arready", t_arready_o, 0);
    chk("rst_f_arready", f_arready_o, 0);
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_arid", arid_o, 0);
    chk("rst_araddr", araddr_o, 0);
    chk("rst_err", err_o, 0);
    #4 rst_n = 1'b1;
    #1;

    // round-robin from reset: T, F, T, F every 2 cycles
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d_t_arready", k), t_arready_o, (k % 2 == 0));
      chk($sformatf("rr%0d_f_arready", k), f_arready_o, (k % 2 == 1));
      step();
      chk($sformatf("rr%0d_arvalid", k), arvalid_o, 1);
      chk($sformatf("rr%0d_arid", k), arid_o, (k % 2 == 0) ? {1'b0, TID} : {1'b1, FID});
      chk($sformatf("rr%0d_araddr", k), araddr_o, (k % 2 == 0) ? TADDR : FADDR);
      chk($sformatf("rr%0d_issue_noready", k), {t_arready_o, f_arready_o}, 0);
      step();
      chk($sformatf("rr%0d_ardone", k), arvalid_o, 0);
    end

    // throttle: cnt_t=2, cnt_f=2; two more T reads fill T
    f_arvalid_i = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("thr%0d_t_arready", j), t_arready_o, 1);
      step();
      chk($sformatf("thr%0d_arvalid", j), arvalid_o, 1);
      step();
    end
    chk("thr_t_blocked", t_arready_o, 0);
    f_arvalid_i = 1'b1;
    #1;
    chk("thr_f_granted", f_arready_o, 1);
    chk("thr_t_blocked2", t_arready_o, 0);
    step();
    f_arvalid_i = 1'b0;
    chk("thr_f_arid", arid_o, {1'b1, FID});
    step();
    chk("thr_t_still_blocked", t_arready_o, 0);
    // last beat for T frees a slot
    rid_i = 17'h00003; rdata_i = 32'h1234_5678; rvalid_i = 1'b1; rlast_i = 1'b1;
    #1;
    chk("r_t_rvalid", t_rvalid_o, 1);
    chk("r_t_f_rvalid", f_rvalid_o, 0);
    chk("r_t_rready", rready_o, 1);
    chk("r_t_rid", t_rid_o, 16'h0003);
    chk("r_t_rdata", t_rdata_o, 32'h1234_5678);
    step();
    rvalid_i = 1'b0; rlast_i = 1'b0; arready_i = 1'b0;
    #1;
    chk("thr_t_released", t_arready_o, 1);
    step();

    // backpressure: arready_i low for 3 cycles, payload holds, no grants
    f_arvalid_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk($sformatf("bp%0d_arvalid", b), arvalid_o, 1);
      chk($sformatf("bp%0d_arid", b), arid_o, {1'b0, TID});
      chk($sformatf("bp%0d_araddr", b), araddr_o, TADDR);
      chk($sformatf("bp%0d_noready", b), {t_arready_o, f_arready_o}, 0);
      step();
    end
    arready_i = 1'b1;
    step();
    chk("bp_arvalid_drop", arvalid_o, 0);
    chk("bp_idle_f_ready", f_arready_o, 1);
    chk("bp_idle_t_full", t_arready_o, 0);

    // reset mid-operation drops an in-flight F read
    arready_i = 1'b0;
    step();
    f_arvalid_i = 1'b0;
    chk("mid_arvalid", arvalid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_arvalid", arvalid_o, 0);
    chk("mid_rst_arid", arid_o, 0);
    chk("mid_rst_araddr", araddr_o, 0);
    chk("mid_rst_t_arready", t_arready_o, 0);
    #2 rst_n = 1'b1;
    t_arvalid_i = 1'b0;

    // R routing to F with F stalled, then late last beat underflows cnt_f
    rid_i = 17'h10005; rdata_i = 32'hDEAD_BEEF; rvalid_i = 1'b1; rlast_i = 1'b1; f_rready_i = 1'b0;
    #1;
    chk("r_f_rvalid", f_rvalid_o, 1);
    chk("r_f_t_rvalid", t_rvalid_o, 0);
    chk("r_f_stall_rready", rready_o, 0);
    chk("r_f_rid", f_rid_o, 16'h0005);
    chk("r_f_rdata", f_rdata_o, 32'hDEAD_BEEF);
    chk("r_f_rlast", f_rlast_o, 1);
    step();
    chk("err_before", err_o, 0);
    f_rready_i = 1'b1;
    #1;
    chk("r_f_rready", rready_o, 1);
    step();
    rvalid_i = 1'b0; rlast_i = 1'b0;
    chk("err_set", err_o, 1);
    step();
    chk("err_sticky", err_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("err_rst_clear", err_o, 0);
    #2 rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
